rr_arb16: RTL and testbench

- 16-requester round-robin arbiter with grant hold and timeout.
- Shares one downstream resource between 16 requesters.
- Winner is chosen by a rotating-priority encode of the request vector: first set bit at or above the pointer, wrapping.
- Grant is registered and held until the resource acks, the requester withdraws, or a watchdog timeout fires.

---
 rtl/rr_arb16.sv | 78 +++++++
 tb/tb_rr_arb16.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/rr_arb16.sv
// rr_arb16: 16-requester round-robin arbiter with grant hold, ack/withdraw release and watchdog timeout
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset
//   req     - request vector, bit i = requester i
//   ack     - single-cycle pulse, resource done with current grant
//   gnt     - registered one-hot grant, zero when idle
//   gnt_idx - binary index of the granted requester (valid with gnt_vld)
//   gnt_vld - a grant is active (|gnt)
//   to_err  - one-cycle pulse when a grant is revoked by timeout
//   ptr     - current round-robin priority pointer
module rr_arb16 #(
  parameter int unsigned N       = 16,
  parameter int unsigned LN      = 4,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          ack,
  output logic [N-1:0]  gnt,
  output logic [LN-1:0] gnt_idx,
  output logic          gnt_vld,
  output logic          to_err,
  output logic [LN-1:0] ptr
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [TO_W-1:0] cnt;
  logic [LN-1:0] arb_p;
  logic [LN:0] win;
  logic busy, wdraw, tmo;
  // first set bit at or above p, wrapping; scanning downward lets the closest index win
  function automatic logic [LN:0] pick(input logic [LN-1:0] p, input logic [N-1:0] r);
    pick = '0;
    for (int k = N - 1; k >= 0; k--)
      if (r[p + LN'(k)]) pick = {1'b1, p + LN'(k)};
  endfunction
  always_comb begin
    busy  = state == BUSY;
    arb_p = busy ? gnt_idx + LN'(1) : ptr;
    win   = pick(arb_p, req);
    wdraw = busy && !ack && !req[gnt_idx];
    tmo   = busy && !ack && req[gnt_idx] && TIMEOUT != 0 && cnt == TO_W'(TIMEOUT);
  end
  assign gnt_vld = |gnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      to_err  <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      to_err <= tmo;
      if (!busy || ack) begin
        if (busy) ptr <= gnt_idx + LN'(1);
        if (win[LN]) begin
          state   <= BUSY;
          gnt     <= N'(1) << win[LN-1:0];
          gnt_idx <= win[LN-1:0];
          cnt     <= TO_W'(1);
        end else begin
          state <= IDLE;
          gnt   <= '0;
          cnt   <= '0;
        end
      end else if (wdraw || tmo) begin
        state <= IDLE;
        gnt   <= '0;
        cnt   <= '0;
        ptr   <= gnt_idx + LN'(1);
      end else if (cnt != '1) begin
        cnt <= cnt + TO_W'(1);
      end
    end
endmodule

// File: tb/tb_rr_arb16.sv
// tb_rr_arb16: directed self-checking bench for rr_arb16 (TIMEOUT=10)
module tb_rr_arb16;
  logic clk = 0, rst = 0, ack = 0;
  logic [15:0] req = '0, gnt;
  logic [3:0] gnt_idx, ptr;
  logic gnt_vld, to_err;
  int n_chk = 0, n_fail = 0;
  rr_arb16 #(.TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .gnt(gnt),
    .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .to_err(to_err), .ptr(ptr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    #2 rst = 0;
    #1 rst = 1;
    req = '0;
    ack = 0;
  endtask
  task automatic grant(input string tag, input logic [15:0] g, input logic [3:0] i);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_idx"}, 32'(gnt_idx), 32'(i));
    chk({tag, "_vld"}, 32'(gnt_vld), 1);
  endtask
  initial begin
    #3;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_vld", 32'(gnt_vld), 0);
    chk("rst_ptr", 32'(ptr), 0);
    chk("rst_toerr", 32'(to_err), 0);
    rst = 1;
    // single request, ack release
    req = 16'h0001;
    tick;
    grant("t1", 16'h0001, 0);
    tick;
    tick;
    ack = 1;
    req = '0;
    tick;
    ack = 0;
    chk("t1_rel_gnt", 32'(gnt), 0);
    chk("t1_rel_ptr", 32'(ptr), 1);
    chk("t1_rel_toerr", 32'(to_err), 0);
    // full request vector, rotation with back-to-back grants
    do_reset;
    req = 16'hFFFF;
    tick;
    grant("t2_first", 16'h0001, 0);
    for (int k = 1; k <= 16; k++) begin
      tick;
      chk("t2_hold_vld", 32'(gnt_vld), 1);
      chk("t2_hold_idx", 32'(gnt_idx), 32'(k - 1));
      ack = 1;
      tick;
      ack = 0;
      grant("t2_rot", 16'(1) << (k % 16), 4'(k % 16));
    end
    req = '0;
    ack = 1;
    tick;
    ack = 0;
    chk("t2_end_vld", 32'(gnt_vld), 0);
    chk("t2_end_ptr", 32'(ptr), 1);
    // wrap-around winner from ptr=5
    do_reset;
    req = 16'h0010;
    tick;
    grant("t3_pre", 16'h0010, 4);
    ack = 1;
    req = '0;
    tick;
    ack = 0;
    chk("t3_ptr", 32'(ptr), 5);
    req = 16'h0011;
    tick;
    grant("t3_wrap", 16'h0001, 0);
    // timeout after 10 held cycles
    do_reset;
    req = 16'h0100;
    tick;
    grant("t4_g", 16'h0100, 8);
    for (int k = 0; k < 9; k++) begin
      tick;
      chk("t4_held", 32'(gnt), 32'h0100);
      chk("t4_no_err", 32'(to_err), 0);
    end
    tick;
    chk("t4_to_gnt", 32'(gnt), 0);
    chk("t4_to_vld", 32'(gnt_vld), 0);
    chk("t4_to_err", 32'(to_err), 1);
    chk("t4_to_ptr", 32'(ptr), 9);
    tick;
    chk("t4_err_pulse", 32'(to_err), 0);
    grant("t4_regrant", 16'h0100, 8);
    // withdrawal release
    do_reset;
    req = 16'h0008;
    tick;
    grant("t5_g", 16'h0008, 3);
    req = 16'h0088;
    tick;
    grant("t5_hold", 16'h0008, 3);
    req = 16'h0080;
    tick;
    chk("t5_wd_gnt", 32'(gnt), 0);
    chk("t5_wd_err", 32'(to_err), 0);
    chk("t5_wd_ptr", 32'(ptr), 4);
    tick;
    grant("t5_next", 16'h0080, 7);
    // ack coinciding with timeout
    do_reset;
    req = 16'h0002;
    tick;
    grant("t6_g", 16'h0002, 1);
    for (int k = 0; k < 9; k++) tick;
    ack = 1;
    tick;
    ack = 0;
    chk("t6_ack_err", 32'(to_err), 0);
    grant("t6_ack_regrant", 16'h0002, 1);
    chk("t6_ack_ptr", 32'(ptr), 2);
    // asynchronous reset mid-grant
    #2 rst = 0;
    #1;
    chk("t6_arst_gnt", 32'(gnt), 0);
    chk("t6_arst_vld", 32'(gnt_vld), 0);
    chk("t6_arst_ptr", 32'(ptr), 0);
    rst = 1;
    req = '0;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
